// File: rtl/rb_osc_decim_fifo.sv
// rtl/rb_osc_decim_fifo.sv - block-averaging decimator feeding a bus-drained FIFO with fill-level irq
// Optional round-half-up of the average: define RB_DECIM_ROUND_EN.
module rb_osc_decim_fifo #(
    parameter int DW      = 16,
    parameter int FIFO_AW = 5
) (
    input  logic          clk_adc_125mhz,
    input  logic          adc_rstn_i,
    input  logic          s_vld_i,
    input  logic [DW-1:0] s_dat_i,
    input  logic [31:0]   sys_addr,
    input  logic [31:0]   sys_wdata,
    input  logic [3:0]    sys_sel,
    input  logic          sys_wen,
    input  logic          sys_ren,
    output logic [31:0]   sys_rdata,
    output logic          sys_err,
    output logic          sys_ack,
    output logic          irq_o
);

    localparam int ACC_W = DW + 7;
    localparam int LW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic {ST_IDLE, ST_ACC} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [6:0]                cnt_q, cnt_d;
    logic [2:0]                s_act_q, s_act_d;
    logic                      en_q, en_d;
    logic [2:0]                s_q, s_d;
    logic [LW-1:0]             thresh_q, thresh_d;
    logic                      ovf_q, ovf_d;
    logic [FIFO_AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]             level_q;
    logic [DW-1:0]             mem_q [DEPTH];
    logic [31:0]               rdata_q, rdata_d;
    logic                      ack_q;
    logic                      irq_q;

    logic [7:0]              addr;
    logic                    wr_ctrl, wr_status, wr_thresh, rd_data;
    logic                    clr, full, empty, pop, push_req, push_ok, overflow;
    logic signed [ACC_W-1:0] acc_sum;
    logic [7:0]              win_len;
    logic                    win_last;
    logic [DW-1:0]           result;
    logic [DW-1:0]           head;
    logic                    unused_bits;

    assign unused_bits = ^{sys_addr[31:8], sys_sel, sys_wdata};

    assign addr      = sys_addr[7:0];
    assign wr_ctrl   = sys_wen && (addr == 8'h00);
    assign wr_status = sys_wen && (addr == 8'h04);
    assign wr_thresh = sys_wen && (addr == 8'h08);
    assign rd_data   = sys_ren && (addr == 8'h0C);
    assign clr       = wr_ctrl && sys_wdata[1];

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        en_d     = en_q;
        s_d      = s_q;
        thresh_d = thresh_q;
        if (wr_ctrl) begin
            en_d = sys_wdata[0];
            s_d  = sys_wdata[10:8];
        end
        if (wr_thresh) begin
            thresh_d = sys_wdata[LW-1:0];
        end
    end

    assign acc_sum  = acc_q + {{(ACC_W-DW){s_dat_i[DW-1]}}, s_dat_i};
    assign win_len  = 8'd1 << s_act_q;
    assign win_last = ({1'b0, cnt_q} == (win_len - 8'd1));

`ifdef RB_DECIM_ROUND_EN
    localparam logic signed [ACC_W:0] MAX_POS = (ACC_W+1)'((2 ** (DW - 1)) - 1);
    logic [ACC_W:0]          rnd_add;
    logic signed [ACC_W:0]   rnd_sum, rnd_shift;
    always_comb begin
        rnd_add   = (s_act_q == 3'd0) ? '0 : ((ACC_W+1)'(1) << (s_act_q - 3'd1));
        rnd_sum   = $signed({acc_sum[ACC_W-1], acc_sum}) + $signed(rnd_add);
        rnd_shift = rnd_sum >>> s_act_q;
        result    = (rnd_shift > MAX_POS) ? MAX_POS[DW-1:0] : rnd_shift[DW-1:0];
    end
`else
    assign result = DW'(acc_sum >>> s_act_q);
`endif

    // EN is evaluated on its next value so the write edge itself opens the window.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        s_act_d  = s_act_q;
        push_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_d) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    s_act_d = s_d;
                end
            end
            ST_ACC: begin
                if (!en_d) begin
                    state_d = ST_IDLE;
                end else if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (s_vld_i) begin
                    if (win_last) begin
                        push_req = 1'b1;
                        acc_d    = '0;
                        cnt_d    = '0;
                        s_act_d  = s_d;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop      = rd_data && !empty && !clr;
    assign push_ok  = push_req && (!full || pop);
    assign overflow = push_req && full && !pop;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && sys_wdata[16]) begin
            ovf_d = 1'b0;
        end
        if (overflow) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (sys_ren) begin
            case (addr)
                8'h00: rdata_d = {21'd0, s_q, 7'd0, en_q};
                8'h04: begin
                    rdata_d[LW-1:0] = level_q;
                    rdata_d[16]     = ovf_q;
                    rdata_d[17]     = empty;
                    rdata_d[18]     = full;
                end
                8'h08: rdata_d = 32'(thresh_q);
                8'h0C: rdata_d = empty ? 32'd0 : {{(32-DW){head[DW-1]}}, head};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_adc_125mhz or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            s_act_q  <= '0;
            en_q     <= 1'b0;
            s_q      <= '0;
            thresh_q <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            s_act_q  <= s_act_d;
            en_q     <= en_d;
            s_q      <= s_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
            ack_q    <= sys_wen || sys_ren;
            irq_q    <= (thresh_q != '0) && (level_q >= thresh_q);
        end
    end

    always_ff @(posedge clk_adc_125mhz or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= result;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign sys_rdata = rdata_q;
    assign sys_ack   = ack_q;
    assign sys_err   = 1'b0;
    assign irq_o     = irq_q;

endmodule
